// File: rtl/bounding_box_pkg.sv
// Shared types and default geometry for the bounding-box demo.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bounding_box_pkg;

  // Scan controller states.
  typedef enum logic [1:0] {
    SCAN  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One RGB pixel as it sits in the image store.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

  // Default image geometry and the coordinate widths derived from it.
  localparam int DEF_IMG_W = 768;
  localparam int DEF_IMG_H = 512;
  localparam int DEF_X_W   = $clog2(DEF_IMG_W);
  localparam int DEF_Y_W   = $clog2(DEF_IMG_H);
  localparam int DEF_A_W   = $clog2(DEF_IMG_W * DEF_IMG_H);

  // Unsigned channel distance, computed one bit wider so it never wraps.
  function automatic logic [8:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/bounding_box_if.sv
// Pixel-to-comparator bus: a pixel goes out, a match bit comes back.
// Latency: combinational.
// Backpressure: none, the comparator answers every cycle.
interface bounding_box_if;
  import bounding_box_pkg::*;

  pix_t pix;
  logic match;

  modport master (output pix, input match);
  modport slave  (input pix, output match);

endinterface

// File: rtl/bounding_box_pixel_match.sv
// Colour-match comparator: per-channel |pix - TARGET| <= TOL on all three channels.
// Latency: combinational.
// Backpressure: none.
module pixel_match
  import bounding_box_pkg::*;
#(
  parameter logic [23:0] TARGET = 24'hFF0000,
  parameter logic [7:0]  TOL    = 8'd48
) (
  bounding_box_if.slave bus
);

  localparam pix_t TGT = pix_t'(TARGET);

  logic [8:0] dr;
  logic [8:0] dg;
  logic [8:0] db;

  assign dr = abs_diff(bus.pix.r, TGT.r);
  assign dg = abs_diff(bus.pix.g, TGT.g);
  assign db = abs_diff(bus.pix.b, TGT.b);

  // Tolerance is inclusive on every channel.
  assign bus.match = (dr <= {1'b0, TOL}) && (dg <= {1'b0, TOL}) && (db <= {1'b0, TOL});

endmodule

// File: rtl/bounding_box_top.sv
// Raster-scans the internal image once after reset and reports the foreground bounding box.
// Latency: done rises IMG_W*IMG_H+2 cycles after reset release (address, RAM, fold stages).
// Backpressure: none; one pixel per cycle, results frozen once done until the next reset.
module bounding_box_top
  import bounding_box_pkg::*;
#(
  parameter int          IMG_W  = DEF_IMG_W,
  parameter int          IMG_H  = DEF_IMG_H,
  parameter int          PIX_W  = 24,
  parameter logic [23:0] TARGET = 24'hFF0000,
  parameter logic [7:0]  TOL    = 8'd48
) (
  input  logic                       CLOCK_50,
  input  logic [3:0]                 KEY,
  output logic                       done,
  output logic                       box_valid,
  output logic [$clog2(IMG_W)-1:0]   min_x,
  output logic [$clog2(IMG_W)-1:0]   max_x,
  output logic [$clog2(IMG_H)-1:0]   min_y,
  output logic [$clog2(IMG_H)-1:0]   max_y
);

  localparam int X_W = $clog2(IMG_W);
  localparam int Y_W = $clog2(IMG_H);
  localparam int A_W = $clog2(IMG_W * IMG_H);
  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  // Image store; loaded from outside the logic, never written here.
  logic [PIX_W-1:0] ram [IMG_W*IMG_H];

  // Only KEY[3] matters; the other keys are deliberately left unsampled.
  logic rst_n;
  logic unused_key;
  assign rst_n      = KEY[3];
  assign unused_key = ^KEY[2:0];

  // Stage 0: scan address and its coordinate tag.
  state_t         state;
  logic [A_W-1:0] addr;
  logic [X_W-1:0] x0;
  logic [Y_W-1:0] y0;
  logic           drain_cnt;
  logic           last_pix;

  // Stage 1: RAM data and the delayed tag.
  logic [PIX_W-1:0] rdata;
  logic [X_W-1:0]   x1;
  logic [Y_W-1:0]   y1;
  logic             v1;

  logic match;

  assign last_pix = (x0 == X_LAST) && (y0 == Y_LAST);

  // Scan controller: walks the image in raster order, then drains the pipeline and latches done.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      state     <= SCAN;
      addr      <= '0;
      x0        <= '0;
      y0        <= '0;
      drain_cnt <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          drain_cnt <= 1'b0;
          if (last_pix) begin
            // Park the address at 0 so the trailing RAM reads stay in range.
            addr  <= '0;
            x0    <= '0;
            y0    <= '0;
            state <= DRAIN;
          end else begin
            addr <= addr + 1'b1;
            if (x0 == X_LAST) begin
              x0 <= '0;
              y0 <= y0 + 1'b1;
            end else begin
              x0 <= x0 + 1'b1;
            end
          end
        end
        DRAIN: begin
          // First cycle folds the last pixel, second cycle publishes done.
          if (drain_cnt) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state <= SCAN;
        end
      endcase
    end
  end

  // Synchronous RAM read, one cycle behind the address.
  always_ff @(posedge CLOCK_50) begin
    rdata <= ram[addr];
  end

  // Carry the coordinate tag alongside the RAM data; valid only for addresses issued while scanning.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      x1 <= '0;
      y1 <= '0;
    end else begin
      v1 <= (state == SCAN);
      x1 <= x0;
      y1 <= y0;
    end
  end

  bounding_box_if mbus ();

  assign mbus.pix = pix_t'(rdata);
  assign match    = mbus.match;

  pixel_match #(
    .TARGET (TARGET),
    .TOL    (TOL)
  ) u_pixel_match (
    .bus (mbus.slave)
  );

  // Stage 2: fold each matching pixel into the running box.
  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      box_valid <= 1'b0;
      min_x     <= X_LAST;
      min_y     <= Y_LAST;
      max_x     <= '0;
      max_y     <= '0;
    end else if (v1 && match) begin
      box_valid <= 1'b1;
      if (x1 < min_x) min_x <= x1;
      if (x1 > max_x) max_x <= x1;
      if (y1 < min_y) min_y <= y1;
      if (y1 > max_y) max_y <= y1;
    end
  end

endmodule

// File: tb/tb_bounding_box_top.sv
// Directed bench for bounding_box_top on an 8x4 image plus a standalone comparator.
// Latency: expects done exactly 34 cycles after reset release.
// Backpressure: n/a.
module tb_bounding_box_top;
  import bounding_box_pkg::*;

  localparam int W = 8;
  localparam int H = 4;

  logic       clk;
  logic [3:0] key;
  logic       done;
  logic       box_valid;
  logic [2:0] min_x;
  logic [2:0] max_x;
  logic [1:0] min_y;
  logic [1:0] max_y;

  int n_checks;
  int n_errors;

  bounding_box_top #(
    .IMG_W (W),
    .IMG_H (H)
  ) dut (
    .CLOCK_50  (clk),
    .KEY       (key),
    .done      (done),
    .box_valid (box_valid),
    .min_x     (min_x),
    .max_x     (max_x),
    .min_y     (min_y),
    .max_y     (max_y)
  );

  // Standalone comparator for exact tolerance-edge checks.
  bounding_box_if tb_bus ();

  pixel_match #(
    .TARGET (24'hFF0000),
    .TOL    (8'd48)
  ) u_pm (
    .bus (tb_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < W*H; i++) dut.ram[i] = 24'h000000;
  endtask

  task automatic set_pix(input int x, input int y, input logic [23:0] v);
    dut.ram[y*W + x] = v;
  endtask

  // Hold reset for one edge and check the cleared outputs.
  task automatic do_reset(input string tag);
    @(negedge clk);
    key[3] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rst_done"},  {31'd0, done},      32'd0);
    check({tag, "_rst_valid"}, {31'd0, box_valid}, 32'd0);
    check({tag, "_rst_minx"},  {29'd0, min_x},     32'd7);
    check({tag, "_rst_miny"},  {30'd0, min_y},     32'd3);
    check({tag, "_rst_maxx"},  {29'd0, max_x},     32'd0);
    check({tag, "_rst_maxy"},  {30'd0, max_y},     32'd0);
  endtask

  // Release reset, check done timing, then the box, then that it stays frozen.
  task automatic run_scan(input string tag, input logic ev,
                          input int mnx, input int mxx, input int mny, input int mxy);
    @(negedge clk);
    key[3] = 1'b1;
    repeat (33) @(posedge clk);
    #1;
    check({tag, "_done_c33"}, {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_done_c34"}, {31'd0, done}, 32'd1);
    check({tag, "_valid"}, {31'd0, box_valid}, {31'd0, ev});
    check({tag, "_minx"}, {29'd0, min_x}, mnx);
    check({tag, "_maxx"}, {29'd0, max_x}, mxx);
    check({tag, "_miny"}, {30'd0, min_y}, mny);
    check({tag, "_maxy"}, {30'd0, max_y}, mxy);
    repeat (6) @(posedge clk);
    #1;
    check({tag, "_hold_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hold_box"}, {27'd0, box_valid, min_x, max_x},
          {27'd0, ev, mnx[2:0], mxx[2:0]});
    check({tag, "_hold_y"}, {28'd0, min_y, max_y}, {28'd0, mny[1:0], mxy[1:0]});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    key      = 4'b0xxx;

    // Comparator edges: exact tolerance, one past it, each channel separately.
    tb_bus.pix = 24'hFF0000; #1 check("pm_exact",    {31'd0, tb_bus.match}, 32'd1);
    tb_bus.pix = 24'hCF3030; #1 check("pm_tol48",    {31'd0, tb_bus.match}, 32'd1);
    tb_bus.pix = 24'hCE0000; #1 check("pm_r49",      {31'd0, tb_bus.match}, 32'd0);
    tb_bus.pix = 24'hFF3100; #1 check("pm_g49",      {31'd0, tb_bus.match}, 32'd0);
    tb_bus.pix = 24'hFF0031; #1 check("pm_b49",      {31'd0, tb_bus.match}, 32'd0);
    tb_bus.pix = 24'h00FF00; #1 check("pm_green",    {31'd0, tb_bus.match}, 32'd0);

    // Empty image (with a non-matching green pixel): no box.
    clear_ram();
    set_pix(6, 1, 24'h00FF00);
    do_reset("empty");
    run_scan("empty", 1'b0, 7, 0, 3, 0);

    // Single exact match at (3,2).
    clear_ram();
    set_pix(3, 2, 24'hFF0000);
    do_reset("single");
    run_scan("single", 1'b1, 3, 3, 2, 2);

    // Opposite corners, including the very first and very last pixel.
    clear_ram();
    set_pix(0, 0, 24'hFF0000);
    set_pix(7, 3, 24'hFF0000);
    do_reset("corners");
    run_scan("corners", 1'b1, 0, 7, 0, 3);

    // Anti-diagonal pair: min/max come from different pixels.
    clear_ram();
    set_pix(5, 1, 24'hFF0000);
    set_pix(2, 3, 24'hFF0000);
    do_reset("diag");
    run_scan("diag", 1'b1, 2, 5, 1, 3);

    // Tolerance edge inside the image: diff 48 matches, diff 49 does not.
    clear_ram();
    set_pix(4, 1, 24'hCF3030);
    do_reset("tol48");
    run_scan("tol48", 1'b1, 4, 4, 1, 1);

    clear_ram();
    set_pix(4, 1, 24'hCE0000);
    do_reset("tol49");
    run_scan("tol49", 1'b0, 7, 0, 3, 0);

    // Reset 15 cycles into a scan aborts it; the rerun gives the full result.
    clear_ram();
    set_pix(5, 1, 24'hFF0000);
    set_pix(2, 3, 24'hFF0000);
    set_pix(1, 0, 24'hFF0000);
    do_reset("abort");
    @(negedge clk);
    key[3] = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_mid_done", {31'd0, done}, 32'd0);
    check("abort_mid_valid", {31'd0, box_valid}, 32'd1);
    do_reset("abort2");
    run_scan("abort", 1'b1, 1, 5, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
